// File: rtl/multi_cycle_ctrl.sv
// EX-stage sequencer for the multi-cycle MUL/DIV datapath: latches operands, pulses start,
// stalls the pipeline until done, writes {hi,lo}, drains on flush and aborts on a stuck datapath.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [7:0]  req_inst,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic        flush,
  output logic        stall_req,
  output logic [7:0]  md_inst,
  output logic [31:0] md_op1,
  output logic [31:0] md_op2,
  output logic        md_start,
  input  logic [63:0] md_result,
  input  logic        md_done,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [7:0] INST_NOP   = 8'h00;
  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_md;
  logic             accept;
  logic             in_flight;
  logic             wd_expire;

  function automatic logic is_md_inst(input logic [7:0] inst);
    return (inst == INST_MULT) || (inst == INST_MULTU) ||
           (inst == INST_DIV)  || (inst == INST_DIVU);
  endfunction

  assign is_md     = is_md_inst(req_inst);
  assign accept    = (state == S_IDLE) && req_valid && is_md && !flush;
  assign in_flight = (state == S_BUSY) || (state == S_DRAIN);
  // A done in the expiry cycle wins over the watchdog.
  assign wd_expire = in_flight && (cnt == CNT_LAST) && !md_done;

  assign busy      = (state != S_IDLE);
  assign hilo_we   = (state == S_WB) && !flush;
  assign stall_req = accept || (state == S_BUSY) ||
                     ((state == S_DRAIN) && req_valid && is_md);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_BUSY;
      S_BUSY: begin
        if (wd_expire)    state_nxt = S_IDLE;
        else if (flush)   state_nxt = md_done ? S_IDLE : S_DRAIN;
        else if (md_done) state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_IDLE;
      S_DRAIN: if (md_done || wd_expire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and operand/result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      md_start    <= 1'b0;
      err_timeout <= 1'b0;
      md_inst     <= INST_NOP;
      md_op1      <= '0;
      md_op2      <= '0;
      hilo_wdata  <= '0;
    end else begin
      state    <= state_nxt;
      md_start <= accept;

      if (accept) begin
        md_inst <= req_inst;
        md_op1  <= req_op1;
        md_op2  <= req_op2;
      end else if ((state_nxt == S_IDLE) || (state_nxt == S_WB)) begin
        md_inst <= INST_NOP;
      end

      if (accept)         cnt <= '0;
      else if (in_flight) cnt <= cnt + 1'b1;

      if ((state == S_BUSY) && md_done && !flush) hilo_wdata <= md_result;

      if (wd_expire) err_timeout <= 1'b1;
    end
  end

endmodule
